// File: rtl/prga_engine.sv
// ARC4 pseudo-random generation and XOR stage: walks the KSA-initialised S array in s_mem,
// decrypts the length-prefixed message from ct_mem and writes it to pt_mem.
module prga_engine #(
  parameter logic [7:0] LEN_ADDR = 8'd0
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_RD,
    S_LEN_WT,
    S_LEN_WR,
    S_RD_SI,
    S_WT_SI,
    S_RD_SJ,
    S_WT_SJ,
    S_WR_SI,
    S_WR_SJ,
    S_RD_PAD,
    S_WT_PAD,
    S_WR_PT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_k;
  logic [7:0] r_len;
  logic [7:0] r_si;
  logic [7:0] r_sj;
  logic [7:0] r_ctByte;
  logic [7:0] r_pad;

  // State register plus the datapath registers each state loads.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_i      <= 8'd0;
      r_j      <= 8'd0;
      r_k      <= 8'd0;
      r_len    <= 8'd0;
      r_si     <= 8'd0;
      r_sj     <= 8'd0;
      r_ctByte <= 8'd0;
      r_pad    <= 8'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_i <= 8'd0;
            r_j <= 8'd0;
            r_k <= 8'd1;
          end
        end
        S_LEN_WT: r_len <= ct_rddata;
        S_LEN_WR: r_i <= 8'd1;
        S_WT_SI: begin
          r_si <= s_rddata;
          r_j  <= r_j + s_rddata;
        end
        S_RD_SJ:  r_ctByte <= ct_rddata;
        S_WT_SJ:  r_sj <= s_rddata;
        S_WT_PAD: r_pad <= s_rddata;
        S_WR_PT: begin
          if (r_k != r_len) begin
            r_k <= r_k + 8'd1;
            r_i <= r_i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The ct address is held through WT_SI so the RAM's registered address still points at byte k
  // when ct_byte is captured in RD_SJ.
  always_comb begin
    w_next    = r_state;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (r_state)
      S_IDLE: begin
        rdy = 1'b1;
        if (en) w_next = S_LEN_RD;
      end
      S_LEN_RD: begin
        ct_addr = LEN_ADDR;
        w_next  = S_LEN_WT;
      end
      S_LEN_WT: begin
        ct_addr = LEN_ADDR;
        w_next  = S_LEN_WR;
      end
      S_LEN_WR: begin
        pt_addr   = LEN_ADDR;
        pt_wrdata = r_len;
        pt_wren   = 1'b1;
        w_next    = (r_len == 8'd0) ? S_IDLE : S_RD_SI;
      end
      S_RD_SI: begin
        s_addr  = r_i;
        ct_addr = LEN_ADDR + r_k;
        w_next  = S_WT_SI;
      end
      S_WT_SI: begin
        ct_addr = LEN_ADDR + r_k;
        w_next  = S_RD_SJ;
      end
      S_RD_SJ: begin
        s_addr = r_j;
        w_next = S_WT_SJ;
      end
      S_WT_SJ: w_next = S_WR_SI;
      S_WR_SI: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = 1'b1;
        w_next   = S_WR_SJ;
      end
      S_WR_SJ: begin
        s_addr   = r_i;
        s_wrdata = r_sj;
        s_wren   = 1'b1;
        w_next   = S_RD_PAD;
      end
      S_RD_PAD: begin
        s_addr = r_si + r_sj;
        w_next = S_WT_PAD;
      end
      S_WT_PAD: w_next = S_WR_PT;
      S_WR_PT: begin
        pt_addr   = LEN_ADDR + r_k;
        pt_wrdata = r_pad ^ r_ctByte;
        pt_wren   = 1'b1;
        w_next    = (r_k == r_len) ? S_IDLE : S_RD_SI;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prga_engine.sv
// Bench for prga_engine: models the three RAMs and checks the decrypted output, the swapped
// S array, write-pulse counts and latency against a plain ARC4 reference.
module tb_prga_engine;
  localparam logic [7:0] LEN_ADDR = 8'd0;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
  logic       s_wren, pt_wren;

  logic [7:0] sMem[256];
  logic [7:0] ctMem[256];
  logic [7:0] ptMem[256];
  logic [7:0] sImage[256];
  logic [7:0] ctImage[256];
  logic [7:0] modelS[256];
  logic [7:0] expPt[256];
  logic [7:0] sAddrQ, ctAddrQ;
  logic       loadReq;
  int         ptWrenTotal = 0;
  int         sWrenTotal = 0;
  int         vectorCount = 0;
  int         missCount = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  prga_engine #(.LEN_ADDR(LEN_ADDR)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  // Single-port RAMs: registered address, unregistered q; loadReq copies the images in one cycle.
  always @(posedge CLOCK_50) begin
    if (loadReq) begin
      for (int a = 0; a < 256; a++) begin
        sMem[a]  <= sImage[a];
        ctMem[a] <= ctImage[a];
        ptMem[a] <= 8'h00;
      end
    end else begin
      if (s_wren) sMem[s_addr] <= s_wrdata;
      if (pt_wren) ptMem[pt_addr] <= pt_wrdata;
    end
    sAddrQ  <= s_addr;
    ctAddrQ <= ct_addr;
    if (pt_wren) ptWrenTotal <= ptWrenTotal + 1;
    if (s_wren) sWrenTotal <= sWrenTotal + 1;
  end

  assign s_rddata  = sMem[sAddrQ];
  assign ct_rddata = ctMem[ctAddrQ];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference ARC4 PRGA: i and j restart from zero on each run; S persists between runs.
  task automatic modelRun();
    int len, ii, jj, t;
    len = ctImage[LEN_ADDR];
    expPt[LEN_ADDR] = ctImage[LEN_ADDR];
    ii = 0;
    jj = 0;
    for (int n = 1; n <= len; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + modelS[ii]) % 256;
      t = modelS[ii];
      modelS[ii] = modelS[jj];
      modelS[jj] = t[7:0];
      expPt[LEN_ADDR + n] = modelS[(modelS[ii] + modelS[jj]) % 256] ^ ctImage[LEN_ADDR + n];
    end
  endtask

  task automatic loadMemories();
    @(negedge CLOCK_50);
    loadReq = 1'b1;
    @(negedge CLOCK_50);
    loadReq = 1'b0;
    for (int a = 0; a < 256; a++) modelS[a] = sImage[a];
  endtask

  task automatic setIdentityS();
    for (int a = 0; a < 256; a++) sImage[a] = a[7:0];
  endtask

  task automatic setRandomCt(input int len);
    for (int a = 0; a < 256; a++) ctImage[a] = 8'($urandom_range(0, 255));
    ctImage[LEN_ADDR] = len[7:0];
  endtask

  // Called at the negedge just after the accepting edge; returns edges elapsed until rdy.
  task automatic waitIdle(output int cycles, input bit pokeEn);
    cycles = 0;
    while (!rdy && cycles < 5000) begin
      if (pokeEn && cycles == 4) en = 1'b1;
      if (pokeEn && cycles == 5) en = 1'b0;
      @(negedge CLOCK_50);
      cycles++;
    end
    en = 1'b0;
  endtask

  task automatic checkResults(input string tag, input int len, input int cycles, input int ptBase, input int sBase);
    checkOutput({tag, "/latency"}, cycles, 3 + 9 * len);
    checkOutput({tag, "/ptWrens"}, ptWrenTotal - ptBase, len + 1);
    checkOutput({tag, "/sWrens"}, sWrenTotal - sBase, 2 * len);
    checkOutput({tag, "/idleBus"}, {s_addr, s_wrdata, ct_addr, pt_addr}, 32'h0);
    checkOutput({tag, "/idleWr"}, {pt_wrdata, s_wren, pt_wren}, 32'h0);
    for (int n = 0; n <= len; n++)
      checkOutput($sformatf("%s/pt[%0d]", tag, n), ptMem[LEN_ADDR + n], expPt[LEN_ADDR + n]);
    for (int a = 0; a < 256; a++)
      checkOutput($sformatf("%s/S[%0d]", tag, a), sMem[a], modelS[a]);
  endtask

  task automatic applyStimulus(input string tag, input bit pokeEn);
    int len, cycles, ptBase, sBase;
    len = ctImage[LEN_ADDR];
    modelRun();
    ptBase = ptWrenTotal;
    sBase = sWrenTotal;
    @(negedge CLOCK_50);
    checkOutput({tag, "/ready"}, rdy, 1);
    en = 1'b1;
    @(negedge CLOCK_50);
    en = 1'b0;
    checkOutput({tag, "/busy"}, rdy, 0);
    waitIdle(cycles, pokeEn);
    checkResults(tag, len, cycles, ptBase, sBase);
    if (pokeEn) begin
      repeat (3) @(negedge CLOCK_50);
      checkOutput({tag, "/stayIdle"}, rdy, 1);
    end
  endtask

  initial begin
    int cycles, ptBase, sBase, len;
    en = 1'b0;
    loadReq = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checkOutput("reset/rdy", rdy, 1);
    checkOutput("reset/bus", {s_addr, s_wrdata, ct_addr, pt_addr}, 32'h0);
    checkOutput("reset/wr", {pt_wrdata, s_wren, pt_wren}, 32'h0);
    rst_n = 1'b1;

    setIdentityS();
    for (int a = 0; a < 256; a++) ctImage[a] = 8'h00;
    ctImage[0] = 8'h01;
    loadMemories();
    applyStimulus("t1", 1'b0);
    checkOutput("t1/const/pt0", ptMem[0], 8'h01);
    checkOutput("t1/const/pt1", ptMem[1], 8'h02);
    checkOutput("t1/const/S1", sMem[1], 8'h01);

    setIdentityS();
    ctImage[0] = 8'h02;
    ctImage[1] = 8'h00;
    ctImage[2] = 8'hFF;
    loadMemories();
    applyStimulus("t2", 1'b0);
    checkOutput("t2/const/pt1", ptMem[1], 8'h02);
    checkOutput("t2/const/pt2", ptMem[2], 8'hFA);
    checkOutput("t2/const/S2", sMem[2], 8'h03);
    checkOutput("t2/const/S3", sMem[3], 8'h02);

    setIdentityS();
    setRandomCt(0);
    loadMemories();
    applyStimulus("t3", 1'b0);
    checkOutput("t3/const/pt0", ptMem[0], 8'h00);

    // Abort during WT_SJ of the first byte, then rerun from scratch.
    setIdentityS();
    setRandomCt(4);
    loadMemories();
    ptBase = ptWrenTotal;
    sBase = sWrenTotal;
    @(negedge CLOCK_50);
    en = 1'b1;
    @(negedge CLOCK_50);
    en = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    rst_n = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("t4/abortRdy", rdy, 1);
    checkOutput("t4/abortWr", {s_wren, pt_wren}, 32'h0);
    rst_n = 1'b1;
    checkOutput("t4/abortPtWrens", ptWrenTotal - ptBase, 1);
    checkOutput("t4/abortSWrens", sWrenTotal - sBase, 0);
    applyStimulus("t4", 1'b0);

    for (int a = 0; a < 256; a++) sImage[a] = 8'($urandom_range(0, 255));
    setRandomCt($urandom_range(5, 12));
    loadMemories();
    applyStimulus("t5poke", 1'b1);

    // en held high: one rdy cycle between back-to-back runs, second run continues from the swapped S.
    for (int a = 0; a < 256; a++) sImage[a] = 8'($urandom_range(0, 255));
    len = $urandom_range(1, 6);
    setRandomCt(len);
    loadMemories();
    modelRun();
    @(negedge CLOCK_50);
    en = 1'b1;
    @(negedge CLOCK_50);
    cycles = 0;
    while (!rdy && cycles < 5000) begin
      @(negedge CLOCK_50);
      cycles++;
    end
    checkOutput("t5hold/latency1", cycles, 3 + 9 * len);
    modelRun();
    ptBase = ptWrenTotal;
    sBase = sWrenTotal;
    @(negedge CLOCK_50);
    checkOutput("t5hold/oneRdy", rdy, 0);
    en = 1'b0;
    waitIdle(cycles, 1'b0);
    checkResults("t5hold", len, cycles, ptBase, sBase);

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 256; a++) sImage[a] = 8'($urandom_range(0, 255));
      setRandomCt($urandom_range(1, 30));
      loadMemories();
      applyStimulus($sformatf("rand%0d", r), 1'b0);
    end

    setIdentityS();
    setRandomCt(255);
    loadMemories();
    applyStimulus("t6", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
